seg_merge_arbiter: RTL

SEG_MERGE_ARBITER -- requirements
Module: seg_merge_arbiter

---
 rtl/seg_merge_arbiter.sv | 72 +++++++
 1 files changed

// File: rtl/seg_merge_arbiter.sv
// Two-requester round-robin write arbiter into an 8-digit, 7-segment buffer,
// with a prescaled multiplexed scan driving registered seg/dsel outputs.
module seg_merge_arbiter #(
  parameter int SCAN_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       a_req,
  input  logic [2:0] a_digit,
  input  logic [6:0] a_pat,
  input  logic       a_merge,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [2:0] b_digit,
  input  logic [6:0] b_pat,
  input  logic       b_merge,
  output logic       b_ack,
  input  logic       clr,
  output logic [6:0] seg,
  output logic [7:0] dsel
);

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

  logic [6:0]  digit_buf [8];
  logic        b_last;
  logic [15:0] presc;
  logic [2:0]  scan_idx;

  // b_last set means B won most recently, so A takes the next contested cycle.
  always_comb begin
    a_ack = 1'b0;
    b_ack = 1'b0;
    if (!RST && !clr) begin
      a_ack = a_req && (!b_req || b_last);
      b_ack = b_req && (!a_req || !b_last);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) digit_buf[i] <= 7'h00;
      b_last   <= 1'b1;
      presc    <= 16'd0;
      scan_idx <= 3'd0;
      seg      <= 7'h00;
      dsel     <= 8'h01;
    end else begin
      seg  <= digit_buf[scan_idx];
      dsel <= 8'h01 << scan_idx;

      if (presc == PRESC_MAX) begin
        presc    <= 16'd0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        presc <= presc + 16'd1;
      end

      // clr wins over any write; the acks are already forced low for it.
      if (clr) begin
        for (int i = 0; i < 8; i++) digit_buf[i] <= 7'h00;
      end else if (a_ack) begin
        digit_buf[a_digit] <= a_merge ? (digit_buf[a_digit] | a_pat) : a_pat;
        b_last             <= 1'b0;
      end else if (b_ack) begin
        digit_buf[b_digit] <= b_merge ? (digit_buf[b_digit] | b_pat) : b_pat;
        b_last             <= 1'b1;
      end
    end
  end

endmodule
